// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file with write-through bypass.
// x0 reads as zero; x2/x3 come out of reset holding sp/gp.
module register_file #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_RESET  = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_RESET  = 32'h1000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [4:0]            Write_Register_i,
  input  logic [4:0]            Read_Register_1_i,
  input  logic [4:0]            Read_Register_2_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

  localparam int unsigned NREG = 32;

  // x1..x31 state; entry 0 exists only as a constant zero in the read view
  logic [DATA_WIDTH-1:0] regs_q [1:NREG-1];
  logic [DATA_WIDTH-1:0] rf_view [0:NREG-1];

  logic                  wr_en;
  logic                  byp_ok;
  logic [DATA_WIDTH-1:0] rd1_d;
  logic [DATA_WIDTH-1:0] rd2_d;

  // writes to x0 are dropped here rather than in the flops
  assign wr_en  = Reg_Write_i && (Write_Register_i != 5'd0);

  // bypass is suppressed while reset holds the array
  assign byp_ok = wr_en && !reset;

  function automatic logic [DATA_WIDTH-1:0] rst_val(input int unsigned idx);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (idx == 2) v = SP_RESET;
    if (idx == 3) v = GP_RESET;
    return v;
  endfunction

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_reg
      // one async-reset flop word per architectural register
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          regs_q[g] <= rst_val(g);
        end else if (wr_en && (Write_Register_i == 5'(g))) begin
          regs_q[g] <= Write_Data_i;
        end
      end
    end
  endgenerate

  // flat 32-entry view so the read index never falls outside the array
  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  // rs1 read: x0 zero, then same-cycle write bypass, then stored value
  always_comb begin
    rd1_d = '0;
    if (Read_Register_1_i != 5'd0) begin
      if (byp_ok && (Read_Register_1_i == Write_Register_i)) begin
        rd1_d = Write_Data_i;
      end else begin
        rd1_d = rf_view[Read_Register_1_i];
      end
    end
  end

  // rs2 read: same priority as rs1, fully independent port
  always_comb begin
    rd2_d = '0;
    if (Read_Register_2_i != 5'd0) begin
      if (byp_ok && (Read_Register_2_i == Write_Register_i)) begin
        rd2_d = Write_Data_i;
      end else begin
        rd2_d = rf_view[Read_Register_2_i];
      end
    end
  end

  assign Read_Data_1_o = rd1_d;
  assign Read_Data_2_o = rd2_d;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected reads are queued at drive
// time and compared when the combinational outputs are sampled.
module tb_register_file;

  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wr;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic [31:0] wd;
  logic [31:0] rd1;
  logic [31:0] rd2;

  register_file dut (
    .clk              (clk),
    .reset            (reset),
    .Reg_Write_i      (we),
    .Write_Register_i (wr),
    .Read_Register_1_i(r1),
    .Read_Register_2_i(r2),
    .Write_Data_i     (wd),
    .Read_Data_1_o    (rd1),
    .Read_Data_2_o    (rd2)
  );

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [0:31];
  int          n_chk;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl[2] = SP;
    mdl[3] = GP;
  endtask

  function automatic logic [31:0] mdl_rd(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (!reset && we && wr == idx) return wd;
    return mdl[idx];
  endfunction

  task automatic drive(input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [4:0] s1,
                       input logic [4:0] s2);
    we = w; wr = a; wd = d; r1 = s1; r2 = s2;
  endtask

  task automatic sample();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".rd1"}, rd1, e.e1);
      chk({e.tag, ".rd2"}, rd2, e.e2);
    end
  endtask

  // directed: constant expectations
  task automatic apply_x(input string tag, input logic w,
                         input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    drive(w, a, d, s1, s2);
    e.tag = tag; e.e1 = e1; e.e2 = e2;
    sb.push_back(e);
    sample();
  endtask

  // model-predicted expectations for the current inputs
  task automatic look(input string tag);
    exp_t e;
    e.tag = tag; e.e1 = mdl_rd(r1); e.e2 = mdl_rd(r2);
    sb.push_back(e);
    sample();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset && we && wr != 5'd0) mdl[wr] = wd;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    mdl_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    apply_x("rst_x0_x2", 0, 0, 0, 0, 2, 32'd0, SP);
    apply_x("rst_x3_x5", 0, 0, 0, 3, 5, GP, 32'd0);
    apply_x("rst_nobyp", 1, 5, 32'h1111, 5, 2, 32'd0, SP);
    tick();
    apply_x("rst_nowr", 0, 0, 0, 5, 3, 32'd0, GP);

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      apply_x("hold", 0, 5'd9, 32'hFFFF, 2, 3, SP, GP);
    end

    apply_x("wr5_byp", 1, 5, 32'hDEAD_BEEF, 5, 5,
            32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tick();
    apply_x("rd5", 0, 0, 0, 5, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    drive(1, 31, 32'h1, 0, 0);
    tick();
    apply_x("rd31_5", 0, 0, 0, 31, 5, 32'h1, 32'hDEAD_BEEF);

    apply_x("x0_wr", 1, 0, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'd0);
    tick();
    apply_x("x0_after", 0, 0, 0, 0, 0, 32'd0, 32'd0);

    drive(1, 7, 32'h10, 0, 0);
    tick();
    drive(1, 8, 32'h33, 0, 0);
    tick();
    apply_x("byp7", 1, 7, 32'h20, 7, 8, 32'h20, 32'h33);
    tick();
    apply_x("x7_after", 0, 0, 0, 7, 8, 32'h20, 32'h33);

    apply_x("we_low", 0, 9, 32'hAAAA_5555, 9, 9, 32'd0, 32'd0);
    tick();
    apply_x("x9_after", 0, 0, 0, 9, 9, 32'd0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      if (i % 4 == 0) r1 = wr;
      look("rand");
      tick();
    end

    drive(1, 2, 32'h1234, 0, 0);
    tick();
    drive(1, 10, 32'h55, 0, 0);
    tick();
    apply_x("pre_rst", 0, 0, 0, 2, 10, 32'h1234, 32'h55);
    apply_x("pend_byp", 1, 10, 32'h99, 2, 10, 32'h1234, 32'h99);
    #2;
    reset = 1'b1;
    mdl_reset();
    apply_x("async_rst", 1, 10, 32'h99, 2, 10, SP, 32'd0);
    tick();
    apply_x("rst_edge", 1, 10, 32'h99, 2, 10, SP, 32'd0);
    #2;
    reset = 1'b0;
    apply_x("rel_mid", 0, 10, 32'h99, 2, 10, SP, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      apply_x("x10_zero", 0, 0, 0, 10, 3, 32'd0, GP);
    end
    drive(1, 10, 32'h77, 0, 0);
    tick();
    apply_x("x10_rewr", 0, 0, 0, 10, 2, 32'h77, SP);

    if (sb.size() != 0) chk("sb_left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit RISC-V integer register file for the single-cycle core; it sits directly upstream of the ALU.
- It supplies the rs1 operand to ALU A_i, and the rs2 operand to ALU B_i through the immediate mux.
- It stores the writeback result (ALU result, load data or PC+4) on the rising clock edge.
- Write-through bypass makes a same-cycle write visible on the read ports; x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- SP_RESET, 32'h7FFF_EFFC, value loaded into x2 (sp) on reset.
- GP_RESET, 32'h1000_8000, value loaded into x3 (gp) on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Reg_Write_i  input  1  write enable from the control unit.
- Write_Register_i  input  5  destination register index (rd).
- Read_Register_1_i  input  5  source index rs1.
- Read_Register_2_i  input  5  source index rs2.
- Write_Data_i  input  DATA_WIDTH  writeback data.
- Read_Data_1_o  output  DATA_WIDTH  rs1 value, feeds the ALU A operand.
- Read_Data_2_o  output  DATA_WIDTH  rs2 value, feeds the B-operand mux and store data.

Behaviour:
- Storage: 31 physical registers, x1..x31. x0 has no storage.
- Reset (asynchronous, takes effect immediately on reset=1, independent of clk):
  - x2 = SP_RESET, x3 = GP_RESET, all other registers = 0.
  - Outputs reflect the reset contents combinationally; for example, reading x2 during reset returns SP_RESET.
  - Writes are ignored while reset=1.
- Write: at posedge clk, if reset=0, Reg_Write_i=1 and Write_Register_i != 0, then reg[Write_Register_i] <= Write_Data_i.
  - A write to x0 is silently dropped.
  - Reg_Write_i=0 leaves all state unchanged.
- Read: combinational, zero latency.
  - Read_Data_n_o = 0 when the index is 0.
  - Otherwise, if Reg_Write_i=1, reset=0 and the index equals Write_Register_i, the output is Write_Data_i (write-through bypass).
  - Otherwise the output is the stored reg[index].
- Both read ports are independent. Both may address the same register, and both may bypass in the same cycle.
- The bypass never applies for index 0, even with Reg_Write_i=1 and Write_Register_i=0.
- Reset deasserting mid-cycle: the first write happens at the first rising edge with reset=0; there is no partial write.
- Reset asserting during a pending write: the write is lost and the register holds its reset value.
- No X propagation: every output is a defined value for every index once reset has been applied.
- Single write port, so there are no write-write collisions. Read/write to the same index is resolved by the bypass, not by read-before-write.
- Implementation: flop array with async-reset flops; no inferred RAM, because reset initialisation is required.

Test Plan:
- Reset with reset=1, read x0, x2, x3, x5 -> outputs 0, 32'h7FFF_EFFC, 32'h1000_8000, 0. Deassert reset, hold Reg_Write_i=0 for 3 cycles -> values unchanged.
- Write x5=32'hDEAD_BEEF, then on the next cycle read rs1=5, rs2=5 -> both outputs 32'hDEAD_BEEF. Write x31=32'h1 -> readback 32'h1, and x5 is still 32'hDEAD_BEEF.
- Write x0=32'hFFFF_FFFF with Reg_Write_i=1 and read rs1=0 in the same and the next cycle -> 0 both times, with no bypass.
- Bypass: x7 holds 32'h10. In one cycle drive Reg_Write_i=1, Write_Register_i=7, Write_Data_i=32'h20, rs1=7, rs2=8 -> Read_Data_1_o=32'h20 before the edge and Read_Data_2_o=x8 contents. After the edge x7=32'h20.
- Write-enable low: Reg_Write_i=0, Write_Register_i=9, Write_Data_i=32'hAAAA_5555 -> x9 stays 0 and there is no bypass on a read of 9.
- Async reset mid-operation:
  - Write x2=32'h1234 and x10=32'h55.
  - Pulse reset between clock edges, coincident with a pending write to x10 -> x2 immediately reads SP_RESET and x10 reads 0 without a clock edge.
  - After release, x10 reads 0 until it is rewritten.
